signed_sat_accumulator: RTL and testbench
=========================================

SIGNED_SAT_ACCUMULATOR -- requirements
Module: signed_sat_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: input sample width in bits, minimum 2.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 10: accumulator and result width, minimum WIDTH.
REQ-003 The block SHALL have parameter BLOCK_LEN, default 4: samples per result, minimum 1.
REQ-004 The block SHALL have parameter SIGNED, default 1: 1 for two's-complement operands and result, 0 for unsigned.
REQ-005 The block SHALL have one clock and reset: clk is the single clock, rising edge; rst is asynchronous, active-high.
REQ-006 The block SHALL have port clk, input, 1 bit: clock.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 The block SHALL have port in_valid, input, 1 bit: in_data is a sample this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: sample, signed or unsigned per SIGNED.
REQ-010 The block SHALL have port clear, input, 1 bit: synchronous abort of the current block.
REQ-011 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse, result available.
REQ-012 The block SHALL have port out_data, output, ACC_WIDTH bits: saturated block sum.
REQ-013 The block SHALL have port out_sat, output, 1 bit: at least one saturation occurred in the reported block; qualified by out_valid.

Function
REQ-014 The block SHALL register each sample in stage 1: stage-1 valid = in_valid & ~clear, and the operand = in_data sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_WIDTH.
REQ-015 On each valid stage-1 operand, stage 2 SHALL compute acc_next = clamp(acc + operand) using ACC_WIDTH+1-bit internal precision.
REQ-016 For SIGNED=1, clamp SHALL limit the result to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
REQ-017 For SIGNED=0, clamp SHALL limit the result to [0, 2^ACC_WIDTH-1].
REQ-018 Saturation SHALL be applied per step, not sticky: later samples add to the clamped value, so a block can recover from a limit.
REQ-019 A per-block flag SHALL be set when any step in the block clamps, and SHALL be cleared at block start.
REQ-020 A sample counter (0..BLOCK_LEN-1) SHALL advance on each stage-2 accumulation and wrap to 0 after the BLOCK_LEN-th sample.
REQ-021 On the BLOCK_LEN-th accumulation, the same edge SHALL:
- load out_data with acc_next;
- load out_sat with (flag | this step clamped);
- assert out_valid;
- set acc to 0 and clear the flag.
REQ-022 Latency SHALL be 2 cycles: for a final sample present at edge t, out_valid is high in the cycle after edge t+1.
REQ-023 out_valid SHALL be high for exactly one cycle per block; out_data and out_sat SHALL hold until the next out_valid.
REQ-024 in_valid gaps of any length SHALL be allowed, and back-to-back samples SHALL be accepted every cycle; the block has no backpressure.
REQ-025 With BLOCK_LEN=1, every sample SHALL produce a result: the clamped, extended sample.
REQ-026 clear SHALL take effect at the next edge:
- zero the stage-1 valid, acc, counter and flag;
- drop the sample presented in the same cycle;
- discard any sample already in stage 1;
- suppress out_valid in the following cycle;
- leave out_data and out_sat unchanged.

Reset
REQ-027 rst SHALL, asynchronously, set all registers to 0: stage-1 valid and operand, acc, counter, flag, out_valid, out_data, out_sat.
REQ-028 After rst deasserts, the first valid sample SHALL begin a new block.
REQ-029 An rst mid-block SHALL discard the partial block without producing out_valid.

Verification
REQ-030 Signed clamp, WIDTH=4, ACC_WIDTH=4, BLOCK_LEN=2, SIGNED=1:
- 4, 7 -> out_data 7, out_sat 1;
- -4, -7 -> out_data -8 (4'b1000), out_sat 1;
- 3, -5 -> out_data -2, out_sat 0.
REQ-031 Recovery, same widths with BLOCK_LEN=4: 7, 7, -8, 1 -> running values 7, 7 (clamp), -1, 0 -> out_data 0, out_sat 1.
REQ-032 Unsigned clamp, WIDTH=4, ACC_WIDTH=4, BLOCK_LEN=2, SIGNED=0: 12, 9 -> out_data 15, out_sat 1; 3, 4 -> out_data 7, out_sat 0.
REQ-033 Defaults, throughput: 100 x4 back-to-back -> out_data 400, out_sat 0, out_valid exactly 2 cycles after the last sample; the same 4 samples with random in_valid gaps -> identical result.
REQ-034 Clear and reset, defaults:
- samples 5, 6, then clear asserted together with sample 7, then 1, 1, 1, 1 -> out_data 4, only one out_valid pulse;
- rst asserted mid-block -> outputs 0 immediately, no pulse;
- the next 4 samples -> a correct fresh sum.

Source files
------------

// File: rtl/signed_sat_accumulator_if.sv
// signed_sat_accumulator_if: sample-in / block-result-out bus of the saturating block accumulator
interface signed_sat_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int ACC_WIDTH = 10
);
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic clear;
  logic out_valid;
  logic [ACC_WIDTH-1:0] out_data;
  logic out_sat;
  modport master (output in_valid, in_data, clear, input out_valid, out_data, out_sat);
  modport slave (input in_valid, in_data, clear, output out_valid, out_data, out_sat);
endinterface

// File: rtl/signed_sat_accumulator.sv
// signed_sat_accumulator: two-stage per-step saturating accumulator emitting one result per BLOCK_LEN samples
module signed_sat_accumulator #(
  parameter int WIDTH = 8,
  parameter int ACC_WIDTH = 10,
  parameter int BLOCK_LEN = 4,
  parameter int SIGNED = 1
) (
  input logic clk,
  input logic rst,
  signed_sat_accumulator_if.slave bus
);
  localparam int CW = BLOCK_LEN > 1 ? $clog2(BLOCK_LEN) : 1;
  localparam logic SX = SIGNED != 0;
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] HI = SX ? SMAX : '1;
  localparam logic [ACC_WIDTH-1:0] LO = SX ? ~SMAX : '0;
  logic s1_valid;
  logic [ACC_WIDTH-1:0] s1_op;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [ACC_WIDTH:0] sum;
  logic [CW-1:0] cnt;
  logic flag;
  logic ovf;
  logic last;
  always_comb begin
    sum = {SX & acc[ACC_WIDTH-1], acc} + {SX & s1_op[ACC_WIDTH-1], s1_op};
    ovf = SX ? sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1] : sum[ACC_WIDTH];
    acc_next = ovf ? ((SX & sum[ACC_WIDTH]) ? LO : HI) : sum[ACC_WIDTH-1:0];
    last = cnt == CW'(BLOCK_LEN - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op <= '0;
      acc <= '0;
      cnt <= '0;
      flag <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_sat <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid & ~bus.clear;
      s1_op <= SX ? ACC_WIDTH'(signed'(bus.in_data)) : ACC_WIDTH'(bus.in_data);
      bus.out_valid <= ~bus.clear & s1_valid & last;
      if (bus.clear) begin
        acc <= '0;
        cnt <= '0;
        flag <= 1'b0;
      end else if (s1_valid) begin
        acc <= last ? '0 : acc_next;
        flag <= ~last & (flag | ovf);
        cnt <= last ? '0 : cnt + CW'(1);
        if (last) begin
          bus.out_data <= acc_next;
          bus.out_sat <= flag | ovf;
        end
      end
    end
endmodule

// File: tb/tb_signed_sat_accumulator.sv
// tb_signed_sat_accumulator: table vectors, clear/reset sequences and randomized blocks against an arithmetic model
module tb_signed_sat_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic clr = 1'b0;
  logic [7:0] din = '0;
  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int aw[5] = '{4, 4, 4, 10, 6};
  int sg[5] = '{1, 1, 0, 1, 1};
  int bl[5] = '{2, 4, 2, 4, 1};
  int wd[5] = '{4, 4, 4, 8, 4};
  typedef struct {int dut; int n; int s[4]; bit gap; int ed; bit es;} vec_t;
  vec_t tbl[9];
  always #5 clk = ~clk;
  signed_sat_accumulator_if #(.WIDTH(4), .ACC_WIDTH(4)) i0 ();
  signed_sat_accumulator_if #(.WIDTH(4), .ACC_WIDTH(4)) i1 ();
  signed_sat_accumulator_if #(.WIDTH(4), .ACC_WIDTH(4)) i2 ();
  signed_sat_accumulator_if #(.WIDTH(8), .ACC_WIDTH(10)) i3 ();
  signed_sat_accumulator_if #(.WIDTH(4), .ACC_WIDTH(6)) i4 ();
  assign i0.in_valid = vld;
  assign i0.in_data = din[3:0];
  assign i0.clear = clr;
  assign i1.in_valid = vld;
  assign i1.in_data = din[3:0];
  assign i1.clear = clr;
  assign i2.in_valid = vld;
  assign i2.in_data = din[3:0];
  assign i2.clear = clr;
  assign i3.in_valid = vld;
  assign i3.in_data = din;
  assign i3.clear = clr;
  assign i4.in_valid = vld;
  assign i4.in_data = din[3:0];
  assign i4.clear = clr;
  signed_sat_accumulator #(.WIDTH(4), .ACC_WIDTH(4), .BLOCK_LEN(2), .SIGNED(1)) u0 (.clk(clk), .rst(rst), .bus(i0));
  signed_sat_accumulator #(.WIDTH(4), .ACC_WIDTH(4), .BLOCK_LEN(4), .SIGNED(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  signed_sat_accumulator #(.WIDTH(4), .ACC_WIDTH(4), .BLOCK_LEN(2), .SIGNED(0)) u2 (.clk(clk), .rst(rst), .bus(i2));
  signed_sat_accumulator #(.WIDTH(8), .ACC_WIDTH(10), .BLOCK_LEN(4), .SIGNED(1)) u3 (.clk(clk), .rst(rst), .bus(i3));
  signed_sat_accumulator #(.WIDTH(4), .ACC_WIDTH(6), .BLOCK_LEN(1), .SIGNED(1)) u4 (.clk(clk), .rst(rst), .bus(i4));
  always @(negedge clk) if (i3.out_valid) pulses <= pulses + 1;
  function automatic logic ov(input int k);
    return k == 0 ? i0.out_valid : k == 1 ? i1.out_valid : k == 2 ? i2.out_valid : k == 3 ? i3.out_valid : i4.out_valid;
  endfunction
  function automatic int od(input int k);
    return k == 0 ? int'(i0.out_data) : k == 1 ? int'(i1.out_data) : k == 2 ? int'(i2.out_data) : k == 3 ? int'(i3.out_data) : int'(i4.out_data);
  endfunction
  function automatic logic os(input int k);
    return k == 0 ? i0.out_sat : k == 1 ? i1.out_sat : k == 2 ? i2.out_sat : k == 3 ? i3.out_sat : i4.out_sat;
  endfunction
  function automatic void model(input int k, input int n, input int s[4], output int d, output bit st);
    int hi = sg[k] != 0 ? (1 << (aw[k] - 1)) - 1 : (1 << aw[k]) - 1;
    int lo = sg[k] != 0 ? -(1 << (aw[k] - 1)) : 0;
    int acc = 0;
    st = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc += s[i];
      if (acc > hi) begin acc = hi; st = 1'b1; end
      else if (acc < lo) begin acc = lo; st = 1'b1; end
    end
    d = acc & ((1 << aw[k]) - 1);
  endfunction
  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic put(input logic v, input int d, input logic c);
    vld = v;
    din = 8'(d);
    clr = c;
    @(posedge clk);
    #1;
    vld = 1'b0;
    clr = 1'b0;
  endtask
  task automatic run_blk(input int k, input int n, input int s[4], input bit gaps, input bit pc, output int d, output bit st, output int lat);
    if (pc) put(1'b0, 0, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) put(1'b0, 0, 1'b0);
      put(1'b1, s[i], 1'b0);
    end
    lat = -1;
    for (int c = 0; c < 8 && lat < 0; c++) begin
      @(negedge clk);
      if (ov(k)) lat = c;
    end
    d = od(k);
    st = os(k);
  endtask
  task automatic check_blk(input string nm, input int k, input int n, input int s[4], input bit gaps, input bit pc, input int ed, input bit es);
    int d, lat;
    bit st;
    run_blk(k, n, s, gaps, pc, d, st, lat);
    chk({nm, " latency"}, lat, 1);
    chk({nm, " data"}, d, ed);
    chk({nm, " sat"}, int'(st), int'(es));
    @(negedge clk);
    chk({nm, " pulse width"}, int'(ov(k)), 0);
  endtask
  initial begin
    int p0, prev, d;
    bit st;
    int s[4];
    tbl[0] = '{0, 2, '{4, 7, 0, 0}, 1'b0, 7, 1'b1};
    tbl[1] = '{0, 2, '{-4, -7, 0, 0}, 1'b0, 8, 1'b1};
    tbl[2] = '{0, 2, '{3, -5, 0, 0}, 1'b0, 14, 1'b0};
    tbl[3] = '{1, 4, '{7, 7, -8, 1}, 1'b0, 0, 1'b1};
    tbl[4] = '{2, 2, '{12, 9, 0, 0}, 1'b0, 15, 1'b1};
    tbl[5] = '{2, 2, '{3, 4, 0, 0}, 1'b0, 7, 1'b0};
    tbl[6] = '{3, 4, '{100, 100, 100, 100}, 1'b0, 400, 1'b0};
    tbl[7] = '{3, 4, '{100, 100, 100, 100}, 1'b1, 400, 1'b0};
    tbl[8] = '{4, 1, '{-3, 0, 0, 0}, 1'b0, 61, 1'b0};
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("reset valid d%0d", k), int'(ov(k)), 0);
      chk($sformatf("reset data d%0d", k), od(k), 0);
      chk($sformatf("reset sat d%0d", k), int'(os(k)), 0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    foreach (tbl[i]) check_blk($sformatf("v%0d", i), tbl[i].dut, tbl[i].n, tbl[i].s, tbl[i].gap, 1'b1, tbl[i].ed, tbl[i].es);
    put(1'b0, 0, 1'b1);
    prev = od(3);
    p0 = pulses;
    put(1'b1, 5, 1'b0);
    put(1'b1, 6, 1'b0);
    put(1'b1, 7, 1'b1);
    @(negedge clk);
    chk("clear keeps data", od(3), prev);
    chk("clear no pulse", int'(ov(3)), 0);
    check_blk("after clear", 3, 4, '{1, 1, 1, 1}, 1'b0, 1'b0, 4, 1'b0);
    repeat (4) @(negedge clk);
    chk("clear pulse count", pulses - p0, 1);
    p0 = pulses;
    put(1'b1, 10, 1'b0);
    put(1'b1, 20, 1'b0);
    put(1'b1, 30, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst data", od(3), 0);
    chk("rst valid", int'(ov(3)), 0);
    chk("rst sat", int'(os(3)), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst no pulse", pulses - p0, 0);
    check_blk("after rst", 3, 4, '{1, 2, 3, 4}, 1'b0, 1'b0, 10, 1'b0);
    for (int b = 0; b < 40; b++) begin
      int k = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) begin
        int r = $urandom_range(0, (1 << wd[k]) - 1);
        s[i] = (sg[k] != 0 && r >= (1 << (wd[k] - 1))) ? r - (1 << wd[k]) : r;
      end
      model(k, bl[k], s, d, st);
      check_blk($sformatf("rand%0d d%0d", b, k), k, bl[k], s, 1'b1, 1'b1, d, st);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
